// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache -- direct-mapped, read-only instruction cache.
//
// Fetch lookups are answered combinationally. On a miss, the whole line is
// refilled word by word from backing memory over a request/acknowledge
// handshake. Words are always fetched in order, starting at word 0. A bus
// error aborts the refill and leaves the line invalid. The error is reported
// to fetch for one cycle.
//
// Optional feature macro: ICACHE_PERF_COUNT_EN builds the hit/miss counters.
// When it is not defined, Hit_Count and Miss_Count are tied to 0.
//
// Ports:
//   CLK, RESET          clock; asynchronous active-high reset
//   Instr_address_fIF   fetch byte address (bits [1:0] ignored)
//   Instr1_2IF          fetched word; 0 unless Valid_2IF == 2'b01
//   Valid_2IF           00 busy/miss, 01 hit, 10 memory error
//   Flush               invalidate all lines
//   Mem_Req, Mem_Addr   refill word request and its word address
//   Mem_Ack, Mem_Data,  refill response; Mem_Err is qualified by Mem_Ack
//   Mem_Err
//   Hit_Count,          performance counters
//   Miss_Count
// -----------------------------------------------------------------------------
module icache #(
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr_address_fIF,
   output logic [31:0] Instr1_2IF,
   output logic [1:0]  Valid_2IF,
   input  logic        Flush,
   output logic        Mem_Req,
   output logic [31:0] Mem_Addr,
   input  logic        Mem_Ack,
   input  logic [31:0] Mem_Data,
   input  logic        Mem_Err,
   output logic [31:0] Hit_Count,
   output logic [31:0] Miss_Count
);
   localparam int LINES  = 1 << INDEX_BITS;
   localparam int WORDS  = 1 << OFFSET_BITS;
   localparam int LINE_W = 30 - OFFSET_BITS;      // word-address bits above the offset
   localparam int TAG_W  = LINE_W - INDEX_BITS;

   typedef enum logic [1:0] {S_IDLE, S_REFILL, S_ERROR} state_e;

   state_e                 state_q;
   logic [LINES-1:0]       valid_q;
   logic [TAG_W-1:0]       tag_q  [LINES];
   logic [31:0]            data_q [LINES*WORDS];
   logic [LINE_W-1:0]      line_q;                // latched {tag, index} of the line being filled
   logic [OFFSET_BITS-1:0] cnt_q;                 // next word to request
   logic                   flush_pend_q;
   logic                   mem_req_q;

   // Fetch address fields
   logic [TAG_W-1:0]       f_tag;
   logic [INDEX_BITS-1:0]  f_index;
   logic [OFFSET_BITS-1:0] f_word;
   assign f_tag   = Instr_address_fIF[31 -: TAG_W];
   assign f_index = Instr_address_fIF[2+OFFSET_BITS +: INDEX_BITS];
   assign f_word  = Instr_address_fIF[2 +: OFFSET_BITS];

   logic unused_addr_bits;
   assign unused_addr_bits = ^Instr_address_fIF[1:0];

   // Refill line fields
   logic [INDEX_BITS-1:0]  r_index;
   logic [TAG_W-1:0]       r_tag;
   assign r_index = line_q[INDEX_BITS-1:0];
   assign r_tag   = line_q[LINE_W-1 -: TAG_W];

   logic hit, fill_ack, last_word, flush_now;
   assign hit       = (state_q == S_IDLE) && valid_q[f_index] && (tag_q[f_index] == f_tag);
   assign fill_ack  = (state_q == S_REFILL) && Mem_Ack && !Mem_Err;
   assign last_word = &cnt_q;
   assign flush_now = Flush | flush_pend_q;

   assign Mem_Req  = mem_req_q;
   assign Mem_Addr = {line_q, cnt_q, 2'b00};

   // Flush is never pending outside REFILL, where hit is already 0,
   // so a pending flush always reads as busy.
   always_comb begin
      // NOTE: defaults first so every path assigns; otherwise a latch is inferred.
      Valid_2IF = 2'b00;
      if (!Flush) begin
         if (state_q == S_ERROR) Valid_2IF = 2'b10;
         else if (hit)           Valid_2IF = 2'b01;
      end
      Instr1_2IF = (Valid_2IF == 2'b01) ? data_q[{f_index, f_word}] : '0;
   end

   // Control FSM
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         line_q       <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         mem_req_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Flush) begin
                  valid_q <= '0;
               end else if (!hit) begin
                  line_q           <= Instr_address_fIF[31:2+OFFSET_BITS];
                  cnt_q            <= '0;
                  valid_q[f_index] <= 1'b0;      // evicted line is never visible half-filled
                  mem_req_q        <= 1'b1;
                  state_q          <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (Flush) flush_pend_q <= 1'b1;
               if (Mem_Ack) begin
                  if (Mem_Err) begin
                     mem_req_q <= 1'b0;
                     state_q   <= S_ERROR;
                  end else begin
                     cnt_q <= cnt_q + OFFSET_BITS'(1);
                     if (last_word) begin
                        valid_q[r_index] <= 1'b1;
                        mem_req_q        <= 1'b0;
                        state_q          <= S_IDLE;
                     end
                  end
                  // A flush seen during the refill wins over the line just filled.
                  if ((Mem_Err || last_word) && flush_now) begin
                     valid_q      <= '0;
                     flush_pend_q <= 1'b0;
                  end
               end
            end
            S_ERROR: begin
               if (Flush) valid_q <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // NOTE: tag and data arrays are not reset; the valid bits alone decide whether their contents are used.
   always_ff @(posedge CLK) begin
      if (fill_ack) data_q[{r_index, cnt_q}] <= Mem_Data;
      if (fill_ack && last_word) tag_q[r_index] <= r_tag;
   end

`ifdef ICACHE_PERF_COUNT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit && !Flush)                            hit_cnt_q  <= hit_cnt_q + 32'd1;
         if ((state_q == S_IDLE) && !Flush && !hit)    miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign Hit_Count  = hit_cnt_q;
   assign Miss_Count = miss_cnt_q;
`else
   assign Hit_Count  = '0;
   assign Miss_Count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache -- scoreboard bench for icache (default parameters).
//
// The driver issues fetches. For each fetch, a line-level cache model predicts
// the response: hit or miss, the expected number of busy cycles, and any error
// report. These predictions go into resp_q. The model also pushes the refill
// word addresses it expects into maddr_q. A separate negedge process does two
// jobs. It acts as the backing memory, answering requests from maddr_q. It
// also pops resp_q whenever the cache presents a response.
// -----------------------------------------------------------------------------
module tb_icache;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] Instr_address_fIF = '0;
   logic [31:0] Instr1_2IF;
   logic [1:0]  Valid_2IF;
   logic        Flush;
   logic        Mem_Req;
   logic [31:0] Mem_Addr;
   logic        Mem_Ack = 1'b0;
   logic [31:0] Mem_Data = '0;
   logic        Mem_Err = 1'b0;
   logic [31:0] Hit_Count, Miss_Count;

   logic flush_idle = 1'b0;
   logic flush_refill = 1'b0;
   assign Flush = flush_idle | flush_refill;

   always #5 CLK = ~CLK;

   icache dut (
      .CLK(CLK), .RESET(RESET),
      .Instr_address_fIF(Instr_address_fIF), .Instr1_2IF(Instr1_2IF), .Valid_2IF(Valid_2IF),
      .Flush(Flush),
      .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data), .Mem_Err(Mem_Err),
      .Hit_Count(Hit_Count), .Miss_Count(Miss_Count)
   );

   typedef enum int {K_HIT, K_ERR} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] addr;
      int          stalls;   // expected busy cycles before the hit, -1 = not predicted
   } resp_t;

   resp_t       resp_q [$];
   logic [31:0] maddr_q [$];

   int n_tests = 0;
   int n_fail  = 0;

   // Stimulus controls shared with the memory responder
   int ack_gap    = 0;       // fixed wait cycles before each ack
   bit rand_gap   = 1'b0;    // random 0..2 wait cycles instead
   int err_word   = -1;      // word of the current fetch's first refill that errors
   bit flush_plan = 1'b0;    // pulse Flush during word 1 of the current fetch's first refill
   int fetch_id   = 0;
   bit in_reset   = 1'b1;

   // Line-level model
   bit          m_valid [16];
   logic [23:0] m_tag   [16];
   int          exp_hits   = 0;
   int          exp_misses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic int stall_exp(input int n_refills);
      return rand_gap ? -1 : n_refills * (1 + 4 * (ack_gap + 1));
   endfunction

   task automatic push_line(input logic [31:0] base, input int last);
      for (int w = 0; w <= last; w++) maddr_q.push_back(base + 32'(w * 4));
      exp_misses++;
   endtask

   task automatic model_invalidate();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   // Called just after a rising edge; predicts the outcome and presents the address.
   task automatic start_fetch(input logic [31:0] addr, input int err, input bit fl);
      int          idx;
      logic [23:0] tag;
      logic [31:0] base;
      idx  = int'(addr[7:4]);
      tag  = addr[31:8];
      base = {addr[31:4], 4'b0000};
      fetch_id++;
      err_word   = err;
      flush_plan = fl;
      if (m_valid[idx] && m_tag[idx] == tag) begin
         resp_q.push_back('{K_HIT, addr, 0});
      end else begin
         m_valid[idx] = 1'b0;
         if (err >= 0) begin
            push_line(base, err);
            resp_q.push_back('{K_ERR, addr, -1});
            push_line(base, 3);
            resp_q.push_back('{K_HIT, addr, stall_exp(1)});
         end else if (fl) begin
            push_line(base, 3);
            push_line(base, 3);
            resp_q.push_back('{K_HIT, addr, stall_exp(2)});
            model_invalidate();
         end else begin
            push_line(base, 3);
            resp_q.push_back('{K_HIT, addr, stall_exp(1)});
         end
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
      end
      exp_hits++;
      Instr_address_fIF = addr;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (resp_q.size() != 0 && n < 400) begin
         @(posedge CLK); #1;
         n++;
      end
      check("fetch_outstanding_after_timeout", 32'(resp_q.size()), 32'd0);
      resp_q.delete();
      maddr_q.delete();
   endtask

   task automatic fetch(input logic [31:0] addr, input int err, input bit fl);
      start_fetch(addr, err, fl);
      wait_done();
   endtask

   task automatic idle_flush_then_fetch(input logic [31:0] addr);
      flush_idle = 1'b1;
      @(posedge CLK); #1;
      flush_idle = 1'b0;
      model_invalidate();
      fetch(addr, -1, 1'b0);
   endtask

   task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_COUNT_EN
      check({tag, "_hit_count"},  Hit_Count,  32'(exp_hits));
      check({tag, "_miss_count"}, Miss_Count, 32'(exp_misses));
`else
      check({tag, "_hit_count"},  Hit_Count,  32'd0);
      check({tag, "_miss_count"}, Miss_Count, 32'd0);
`endif
   endtask

   // Monitor and backing memory
   initial begin
      resp_t       e;
      logic [31:0] cur;
      int          w;
      int          stall    = 0;
      bit          req_next = 1'b0;
      int          gap_left = -1;
      int          err_used = -1;
      int          fl_used  = -1;
      forever begin
         @(negedge CLK);
         flush_refill = 1'b0;
         Mem_Ack      = 1'b0;
         Mem_Err      = 1'b0;
         Mem_Data     = '0;
         if (in_reset) begin
            stall    = 0;
            req_next = 1'b0;
            gap_left = -1;
         end else begin
            // Responses to fetch
            if (Valid_2IF == 2'b01 || Valid_2IF == 2'b10) begin
               if (resp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_response: Valid_2IF=%b with nothing outstanding", Valid_2IF);
               end else begin
                  e = resp_q.pop_front();
                  check("resp_kind", 32'(Valid_2IF), (e.kind == K_HIT) ? 32'd1 : 32'd2);
                  if (Valid_2IF == 2'b01) begin
                     check("instr_data", Instr1_2IF, word_of(e.addr));
                     if (e.stalls >= 0) check("busy_cycles", 32'(stall), 32'(e.stalls));
                  end
               end
               stall = 0;
            end else begin
               check("valid_code_busy", 32'(Valid_2IF), 32'd0);
               if (resp_q.size() != 0) stall++;
            end
            if (Valid_2IF != 2'b01) check("instr_zero_when_not_hit", Instr1_2IF, 32'd0);

            // Refill requests
            if (req_next) check("mem_req_held_between_words", 32'(Mem_Req), 32'd1);
            req_next = 1'b0;
            if (Mem_Req) begin
               if (maddr_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_mem_req: Mem_Addr=0x%08h", Mem_Addr);
               end else begin
                  cur = maddr_q[0];
                  w   = int'(cur[3:2]);
                  check("mem_addr", Mem_Addr, cur);
                  if (flush_plan && w == 1 && fl_used != fetch_id) begin
                     flush_refill = 1'b1;
                     fl_used      = fetch_id;
                  end
                  if (gap_left < 0) gap_left = rand_gap ? int'($urandom_range(0, 2)) : ack_gap;
                  if (gap_left > 0) begin
                     gap_left--;
                  end else begin
                     gap_left = -1;
                     Mem_Ack  = 1'b1;
                     if (w == err_word && err_used != fetch_id) begin
                        Mem_Err  = 1'b1;
                        Mem_Data = $urandom;
                        err_used = fetch_id;
                     end else begin
                        Mem_Data = word_of(cur);
                        req_next = (w != 3);
                     end
                     void'(maddr_q.pop_front());
                  end
               end
            end
         end
      end
   end

   // Driver
   initial begin
      logic [31:0] a;
      int          r;
      model_invalidate();
      repeat (3) @(posedge CLK);
      #1;
      check("reset_valid",      32'(Valid_2IF), 32'd0);
      check("reset_instr",      Instr1_2IF,     32'd0);
      check("reset_mem_req",    32'(Mem_Req),   32'd0);
      check("reset_mem_addr",   Mem_Addr,       32'd0);
      check("reset_hit_count",  Hit_Count,      32'd0);
      check("reset_miss_count", Miss_Count,     32'd0);

      // First fill, then hits on the remaining words of the line
      start_fetch(32'hBFC0_0000, -1, 1'b0);
      RESET    = 1'b0;
      in_reset = 1'b0;
      wait_done();
      fetch(32'hBFC0_0004, -1, 1'b0);
      fetch(32'hBFC0_0008, -1, 1'b0);
      fetch(32'hBFC0_000C, -1, 1'b0);
      check_counters("after_first_line");

      // Same index, different tag: conflict eviction
      fetch(32'hBFC0_0100, -1, 1'b0);
      fetch(32'hBFC0_0000, -1, 1'b0);

      // Stalled acks
      ack_gap = 3;
      fetch(32'hBFC0_0040, -1, 1'b0);
      fetch(32'hBFC0_0044, -1, 1'b0);
      ack_gap = 0;

      // Bus error on word 2, then retry
      fetch(32'hBFC0_0080, 2, 1'b0);
      fetch(32'hBFC0_0084, -1, 1'b0);

      // Flush during a refill, then a line filled earlier must miss
      fetch(32'h0000_1230, -1, 1'b1);
      fetch(32'hBFC0_0000, -1, 1'b0);

      // Flush while idle
      idle_flush_then_fetch(32'hBFC0_0044);
      check_counters("after_directed");

      // Reset in the middle of a refill
      start_fetch(32'h0000_2340, -1, 1'b0);
      repeat (2) begin @(posedge CLK); #1; end
      RESET    = 1'b1;
      in_reset = 1'b1;
      resp_q.delete();
      maddr_q.delete();
      model_invalidate();
      exp_hits   = 0;
      exp_misses = 0;
      #2;
      check("midreset_valid",    32'(Valid_2IF), 32'd0);
      check("midreset_mem_req",  32'(Mem_Req),   32'd0);
      check("midreset_mem_addr", Mem_Addr,       32'd0);
      check_counters("midreset");
      @(posedge CLK); #1;
      start_fetch(32'h0000_2340, -1, 1'b0);
      RESET    = 1'b0;
      in_reset = 1'b0;
      wait_done();

      // Random traffic over a small address pool, fixed then random ack timing
      for (int phase = 0; phase < 2; phase++) begin
         rand_gap = (phase == 1);
         for (int i = 0; i < 150; i++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            r = int'($urandom_range(0, 99));
            if (r < 6)       fetch(a, int'($urandom_range(0, 3)), 1'b0);
            else if (r < 12) fetch(a, -1, 1'b1);
            else if (r < 16) idle_flush_then_fetch(a);
            else             fetch(a, -1, 1'b0);
         end
      end
      check_counters("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
